// File: rtl/branch_resolve_predict.sv
// Branch/jump resolution with a 2-bit bimodal predictor; redirect/flush registered, one cycle after resolve.
// No backpressure: resolutions arriving during the post-redirect squash window are dropped.
module branch_resolve_predict #(
  parameter int XLEN       = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int SQUASH_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [XLEN-1:0]   FetchPC,
  output logic              PredTaken,
  input  logic              ResValid,
  input  logic [3:0]        BranchSel,
  input  logic              Zero,
  input  logic [XLEN-1:0]   ALUResult,
  input  logic [XLEN-1:0]   AddResult,
  input  logic [XLEN-5:0]   Imm,
  input  logic [XLEN-1:0]   ResPC,
  input  logic              ResPredTaken,
  output logic              PCSrc,
  output logic [XLEN-1:0]   PCNew,
  output logic              Flush,
  output logic [CNT_W-1:0]  MispredCount
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int SQ_W  = (SQUASH_CYC < 2) ? 1 : $clog2(SQUASH_CYC + 1);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic [0:0]       state_q, state_d;
  logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;
  logic             pcsrc_q, pcsrc_d;
  logic [XLEN-1:0]  pcnew_q, pcnew_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] mispred_q, mispred_d;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic             a_neg;
  logic             a_zero;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  fallthrough;
  logic             accept;
  logic             is_cond;
  logic             redirect;
  logic [1:0]       cur_cnt;
  logic             unused_fetch_bits;

  assign fetch_idx = FetchPC[IDX_W+1:2];
  assign res_idx   = ResPC[IDX_W+1:2];
  assign unused_fetch_bits = ^{FetchPC[XLEN-1:IDX_W+2], FetchPC[1:0]};

  // Combinational read of the pre-update entry; a same-cycle train shows up next cycle.
  assign PredTaken = bht_q[fetch_idx][1];

  always_comb begin
    a_neg       = ALUResult[XLEN-1];
    a_zero      = (ALUResult == '0);
    fallthrough = ResPC + XLEN'(4);
    taken       = 1'b0;
    target      = AddResult;
    case (BranchSel)
      4'd0:    taken = !a_neg;
      4'd1:    taken = Zero;
      4'd2:    taken = !Zero;
      4'd3:    taken = !a_neg && !a_zero;
      4'd4:    taken = a_neg || a_zero;
      4'd5:    taken = a_neg;
      4'd6: begin
        taken  = 1'b1;
        target = {ResPC[XLEN-1:XLEN-4], Imm};
      end
      4'd7: begin
        taken  = 1'b1;
        target = ALUResult;
      end
      4'd8:    taken = 1'b1;
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase

    accept   = ResValid && (state_q == ST_RUN) && (BranchSel <= 4'd8);
    is_cond  = (BranchSel <= 4'd5);
    redirect = accept && (!is_cond || (taken != ResPredTaken));
    cur_cnt  = bht_q[res_idx];

    bht_d = bht_q;
    if (accept && is_cond) begin
      if (taken) bht_d[res_idx] = (cur_cnt == 2'b11) ? 2'b11 : cur_cnt + 2'b01;
      else       bht_d[res_idx] = (cur_cnt == 2'b00) ? 2'b00 : cur_cnt - 2'b01;
    end

    pcsrc_d = redirect;
    flush_d = redirect;
    pcnew_d = '0;
    if (redirect) pcnew_d = (is_cond && !taken) ? fallthrough : target;

    mispred_d = mispred_q;
    if (redirect && (mispred_q != {CNT_W{1'b1}})) mispred_d = mispred_q + CNT_W'(1);

    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (state_q == ST_SQUASH) begin
      if (sq_cnt_q <= SQ_W'(1)) begin
        state_d  = ST_RUN;
        sq_cnt_d = '0;
      end else begin
        sq_cnt_d = sq_cnt_q - SQ_W'(1);
      end
    end else if (redirect && (SQUASH_CYC > 0)) begin
      state_d  = ST_SQUASH;
      sq_cnt_d = SQ_W'(SQUASH_CYC);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      state_q   <= ST_RUN;
      sq_cnt_q  <= '0;
      pcsrc_q   <= 1'b0;
      pcnew_q   <= '0;
      flush_q   <= 1'b0;
      mispred_q <= '0;
    end else begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= bht_d[i];
      state_q   <= state_d;
      sq_cnt_q  <= sq_cnt_d;
      pcsrc_q   <= pcsrc_d;
      pcnew_q   <= pcnew_d;
      flush_q   <= flush_d;
      mispred_q <= mispred_d;
    end
  end

  assign PCSrc        = pcsrc_q;
  assign PCNew        = pcnew_q;
  assign Flush        = flush_q;
  assign MispredCount = mispred_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: hand-computed redirects, predictor training, squash and reset.
module tb_branch_resolve_predict;

  logic        Clk;
  logic        Rst;
  logic [31:0] FetchPC;
  logic        PredTaken;
  logic        ResValid;
  logic [3:0]  BranchSel;
  logic        Zero;
  logic [31:0] ALUResult;
  logic [31:0] AddResult;
  logic [27:0] Imm;
  logic [31:0] ResPC;
  logic        ResPredTaken;
  logic        PCSrc;
  logic [31:0] PCNew;
  logic        Flush;
  logic [15:0] MispredCount;

  int n_cmp = 0;
  int n_bad = 0;

  branch_resolve_predict #(
    .XLEN(32), .BHT_DEPTH(64), .SQUASH_CYC(2), .CNT_W(16)
  ) dut (
    .Clk(Clk), .Rst(Rst), .FetchPC(FetchPC), .PredTaken(PredTaken),
    .ResValid(ResValid), .BranchSel(BranchSel), .Zero(Zero),
    .ALUResult(ALUResult), .AddResult(AddResult), .Imm(Imm), .ResPC(ResPC),
    .ResPredTaken(ResPredTaken), .PCSrc(PCSrc), .PCNew(PCNew), .Flush(Flush),
    .MispredCount(MispredCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_res(input logic [3:0] sel, input logic z, input logic [31:0] alu,
                         input logic [31:0] add, input logic [27:0] imm,
                         input logic [31:0] pc, input logic pred);
    ResValid     = 1'b1;
    BranchSel    = sel;
    Zero         = z;
    ALUResult    = alu;
    AddResult    = add;
    Imm          = imm;
    ResPC        = pc;
    ResPredTaken = pred;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    ResValid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic src, input logic [31:0] pcn,
                            input logic [15:0] cnt);
    check({tag, "_pcsrc"}, 32'(PCSrc), 32'(src));
    check({tag, "_flush"}, 32'(Flush), 32'(src));
    check({tag, "_pcnew"}, PCNew, pcn);
    check({tag, "_count"}, 32'(MispredCount), 32'(cnt));
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    FetchPC = pc;
    #1;
    check(tag, 32'(PredTaken), 32'(exp));
  endtask

  initial begin
    Rst = 1'b1;
    FetchPC = '0;
    set_res(4'd0, 1'b0, 32'h0, 32'h0, 28'h0, 32'h0, 1'b0);
    ResValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Reset state: all entries weakly not-taken, outputs cleared
    for (int i = 0; i < 64; i++) check_pred("rst_pred", 32'(i) << 2, 1'b0);
    check_outs("rst", 1'b0, 32'h0, 16'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // beq taken, predicted not-taken -> redirect to AddResult; entry 0 -> 2'b10
    set_res(4'd1, 1'b1, 32'h0, 32'h140, 28'h0, 32'h100, 1'b0);
    tick();
    check_outs("beq", 1'b1, 32'h140, 16'd1);
    check_pred("beq_train", 32'h100, 1'b1);
    tick();
    check_outs("beq_n2", 1'b0, 32'h0, 16'd1);
    tick();

    // bne not taken, predicted taken -> fallthrough wraps to 0
    set_res(4'd2, 1'b1, 32'h0, 32'h1234, 28'h0, 32'hFFFF_FFFC, 1'b1);
    tick();
    check_outs("bne_wrap", 1'b1, 32'h0, 16'd2);
    check_pred("bne_train", 32'hFFFF_FFFC, 1'b0);
    tick();
    tick();

    // bltz taken, predicted taken: no redirect; same-cycle fetch sees pre-update value
    set_res(4'd5, 1'b0, 32'h8000_0000, 32'h300, 28'h0, 32'h204, 1'b1);
    check_pred("bltz_pre", 32'h204, 1'b0);
    tick();
    check_outs("bltz", 1'b0, 32'h0, 16'd2);
    check_pred("bltz_post", 32'h204, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_res(4'd5, 1'b0, 32'h8000_0000, 32'h300, 28'h0, 32'h204, 1'b1);
      tick();
    end
    check_outs("bltz_rep", 1'b0, 32'h0, 16'd2);
    // Saturated at 3: one not-taken step leaves it predicting taken
    set_res(4'd0, 1'b0, 32'h8000_0000, 32'h300, 28'h0, 32'h204, 1'b1);
    tick();
    check_outs("bgez_nt", 1'b1, 32'h208, 16'd3);
    check_pred("sat_hold", 32'h204, 1'b1);
    tick();
    tick();

    // j pseudo-direct, then two squashed resolutions, third accepted
    set_res(4'd6, 1'b0, 32'h0, 32'h0, 28'h0000040, 32'h3000_0010, 1'b0);
    tick();
    check_outs("j", 1'b1, 32'h3000_0040, 16'd4);
    set_res(4'd8, 1'b0, 32'h0, 32'h500, 28'h0, 32'h400, 1'b0);
    tick();
    check_outs("sq1", 1'b0, 32'h0, 16'd4);
    set_res(4'd8, 1'b0, 32'h0, 32'h500, 28'h0, 32'h400, 1'b0);
    tick();
    check_outs("sq2", 1'b0, 32'h0, 16'd4);
    set_res(4'd8, 1'b0, 32'h0, 32'h500, 28'h0, 32'h400, 1'b0);
    tick();
    check_outs("jal_acc", 1'b1, 32'h500, 16'd5);
    tick();
    tick();

    // jr target, then illegal kinds ignored
    set_res(4'd7, 1'b0, 32'h0000_8888, 32'h500, 28'h0, 32'h400, 1'b0);
    tick();
    check_outs("jr", 1'b1, 32'h8888, 16'd6);
    tick();
    tick();
    set_res(4'd12, 1'b1, 32'h0, 32'h700, 28'h0, 32'h204, 1'b0);
    tick();
    check_outs("sel12", 1'b0, 32'h0, 16'd6);
    set_res(4'd15, 1'b0, 32'h0, 32'h700, 28'h0, 32'h204, 1'b1);
    tick();
    check_outs("sel15", 1'b0, 32'h0, 16'd6);
    check_pred("sel_notrain", 32'h204, 1'b1);

    // Reset mid-squash with redirect pending
    set_res(4'd8, 1'b0, 32'h0, 32'h900, 28'h0, 32'h400, 1'b0);
    tick();
    check_outs("pre_rst", 1'b1, 32'h900, 16'd7);
    Rst = 1'b1;
    #1;
    check_outs("mid_rst", 1'b0, 32'h0, 16'd0);
    check_pred("rst_e0", 32'h100, 1'b0);
    check_pred("rst_e1", 32'h204, 1'b0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    tick();
    check_outs("post_rst", 1'b0, 32'h0, 16'd0);
    // Entry back at 2'b01: one taken step flips prediction
    set_res(4'd1, 1'b1, 32'h0, 32'h300, 28'h0, 32'h204, 1'b1);
    tick();
    check_outs("post_beq", 1'b0, 32'h0, 16'd0);
    check_pred("post_train", 32'h204, 1'b1);
    set_res(4'd8, 1'b0, 32'h0, 32'h600, 28'h0, 32'h400, 1'b0);
    tick();
    check_outs("post_jal", 1'b1, 32'h600, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
